// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the two-requester multiplier arbiter.
// Also holds the round-robin winner selection.
package mult_arbiter_pkg;

  localparam int OpWidth  = 4;
  localparam int ResWidth = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // On a tie the requester that was not served last wins.
  function automatic logic pickWinner(input logic req0, input logic req1,
                                      input logic lastServed);
    if (req0 && req1) begin
      return ~lastServed;
    end
    return req1;
  endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// Unsigned 4x4 combinational multiplier with a full-width 8-bit product.
module mult_arbiter_mult
  import mult_arbiter_pkg::*;
(
  input  logic [OpWidth-1:0]  a_i,
  input  logic [OpWidth-1:0]  b_i,
  output logic [ResWidth-1:0] p_o
);

  assign p_o = ResWidth'(a_i) * ResWidth'(b_i);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one multiplier between two requesters.
// Each operation is one grant cycle followed by a held result awaiting handshake.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic [OpWidth-1:0]  a0,
  input  logic [OpWidth-1:0]  b0,
  output logic                gnt0,
  input  logic                req1,
  input  logic [OpWidth-1:0]  a1,
  input  logic [OpWidth-1:0]  b1,
  output logic                gnt1,
  output logic [ResWidth-1:0] res,
  output logic                res_id,
  output logic                res_valid,
  input  logic                res_ready
);

  state_e               state_q;
  logic [OpWidth-1:0]   opA_q;
  logic [OpWidth-1:0]   opB_q;
  logic                 id_q;
  logic                 lastServed_q;
  logic                 gnt0_q;
  logic                 gnt1_q;
  logic [ResWidth-1:0]  res_q;
  logic                 resId_q;
  logic                 resValid_q;
  logic                 winner_d;
  logic [ResWidth-1:0]  product;

  assign winner_d = pickWinner(req0, req1, lastServed_q);

  mult_arbiter_mult uMult (
    .a_i (opA_q),
    .b_i (opB_q),
    .p_o (product)
  );

  // Operands are latched on entry to BUSY, so later input changes cannot reach res.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      opA_q        <= '0;
      opB_q        <= '0;
      id_q         <= 1'b0;
      lastServed_q <= ~PRIO_RESET;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      res_q        <= '0;
      resId_q      <= 1'b0;
      resValid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            id_q    <= winner_d;
            opA_q   <= winner_d ? a1 : a0;
            opB_q   <= winner_d ? b1 : b0;
            gnt0_q  <= ~winner_d;
            gnt1_q  <= winner_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          res_q      <= product;
          resId_q    <= id_q;
          resValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            resValid_q   <= 1'b0;
            lastServed_q <= resId_q;
            state_q      <= IDLE;
          end
        end
        default: begin
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          resValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign res       = res_q;
  assign res_id    = resId_q;
  assign res_valid = resValid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios then random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_mult_arbiter;

  localparam bit Prio = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [2];
  logic [3:0] a   [2];
  logic [3:0] b   [2];
  logic       resReady = 1'b0;
  logic       gnt0, gnt1, resId, resValid;
  logic [7:0] res;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding job, described as grant -> result -> accept.
  bit mGnt [2];
  bit mValid;
  int mRes;
  bit mId;
  bit mLast;
  bit mWin;
  int mA, mB;

  mult_arbiter #(.PRIO_RESET(Prio)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req[0]),
    .a0        (a[0]),
    .b0        (b[0]),
    .gnt0      (gnt0),
    .req1      (req[1]),
    .a1        (a[1]),
    .b1        (b[1]),
    .gnt1      (gnt1),
    .res       (res),
    .res_id    (resId),
    .res_valid (resValid),
    .res_ready (resReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelUpdate();
    if (rst) begin
      mGnt[0] = 0; mGnt[1] = 0;
      mValid = 0; mRes = 0; mId = 0; mA = 0; mB = 0;
      mLast = !Prio;
    end else if (mGnt[0] || mGnt[1]) begin
      mRes = mA * mB;
      mId = mWin;
      mValid = 1;
      mGnt[0] = 0; mGnt[1] = 0;
    end else if (mValid) begin
      if (resReady) begin
        mValid = 0;
        mLast = mId;
      end
    end else if (req[0] || req[1]) begin
      if (req[0] && req[1]) mWin = !mLast;
      else                  mWin = req[1];
      mA = int'(a[mWin]);
      mB = int'(b[mWin]);
      mGnt[mWin] = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput("gnt0", gnt0, mGnt[0]);
    checkOutput("gnt1", gnt1, mGnt[1]);
    checkOutput("res_valid", resValid, mValid);
    checkOutput("res", res, mRes);
    checkOutput("res_id", resId, mId);
    checkOutput("oneGrant", gnt0 & gnt1, 0);
  endtask

  task automatic applyStimulus();
    rst = ($urandom_range(0, 59) == 0);
    for (int i = 0; i < 2; i++) begin
      if (req[i] && mGnt[i]) begin
        req[i] = 1'($urandom_range(0, 1));
        a[i] = 4'($urandom_range(0, 15));
        b[i] = 4'($urandom_range(0, 15));
      end else if (!req[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          a[i] = 4'($urandom_range(0, 15));
          b[i] = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        req[i] = 1'b0;
      end
    end
    resReady = 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; a[i] = 4'd0; b[i] = 4'd0;
    end
    mLast = !Prio;
    step();
    step();
    checkOutput("rst_gnt0", gnt0, 0);
    checkOutput("rst_gnt1", gnt1, 0);
    checkOutput("rst_valid", resValid, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_id", resId, 0);
    rst = 1'b0;

    // Single request 3*5.
    req[0] = 1; a[0] = 3; b[0] = 5;
    step();
    checkOutput("single_gnt0", gnt0, 1);
    req[0] = 0;
    step();
    checkOutput("single_valid", resValid, 1);
    checkOutput("single_res", res, 15);
    checkOutput("single_id", resId, 0);
    step();
    step();
    checkOutput("single_hold", res, 15);
    resReady = 1;
    step();
    checkOutput("single_accept", resValid, 0);
    resReady = 0;

    // Simultaneous requests alternate after reset.
    rst = 1;
    step();
    rst = 0;
    req[0] = 1; a[0] = 7; b[0] = 7;
    req[1] = 1; a[1] = 15; b[1] = 15;
    step();
    checkOutput("tie_first_gnt0", gnt0, 1);
    step();
    checkOutput("tie_res49", res, 49);
    checkOutput("tie_id0", resId, 0);
    resReady = 1;
    step();
    resReady = 0;
    step();
    checkOutput("tie_second_gnt1", gnt1, 1);
    step();
    checkOutput("tie_res225", res, 225);
    checkOutput("tie_id1", resId, 1);
    resReady = 1;
    step();
    resReady = 0;
    step();
    checkOutput("tie_third_gnt0", gnt0, 1);
    req[0] = 0; req[1] = 0;
    step();
    resReady = 1;
    step();
    resReady = 0;

    // Pending result stalls a new request.
    req[0] = 1; a[0] = 2; b[0] = 6;
    step();
    req[0] = 0; req[1] = 1; a[1] = 3; b[1] = 3;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("stall_gnt1", gnt1, 0);
      checkOutput("stall_res", res, 12);
      checkOutput("stall_valid", resValid, 1);
    end
    resReady = 1;
    step();
    resReady = 0;
    step();
    checkOutput("stall_release_gnt1", gnt1, 1);
    req[1] = 0;
    step();
    checkOutput("stall_res9", res, 9);
    resReady = 1;
    step();
    resReady = 0;

    // Reset during BUSY aborts the job.
    req[0] = 1; a[0] = 15; b[0] = 10;
    step();
    checkOutput("abort_gnt0", gnt0, 1);
    req[0] = 0; rst = 1;
    step();
    checkOutput("abort_gnt0_clr", gnt0, 0);
    checkOutput("abort_valid", resValid, 0);
    checkOutput("abort_res", res, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("abort_no150", res, 0);
      checkOutput("abort_no_gnt", gnt0, 0);
    end

    // Operands changed after latching.
    req[1] = 1; a[1] = 15; b[1] = 5;
    step();
    req[1] = 0; a[1] = 0; b[1] = 0;
    step();
    checkOutput("latch_res75", res, 75);
    checkOutput("latch_id1", resId, 1);
    resReady = 1;
    step();
    resReady = 0;

    // Zero operand.
    req[0] = 1; a[0] = 15; b[0] = 0;
    step();
    req[0] = 0;
    step();
    checkOutput("zero_valid", resValid, 1);
    checkOutput("zero_res", res, 0);
    resReady = 1;
    step();
    checkOutput("zero_accept", resValid, 0);
    resReady = 0;

    for (int n = 0; n < 600; n++) begin
      applyStimulus();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
